// File: rtl/param_datapath_if.sv
// ---------------------------------------------------------------------------
// param_datapath_if
//  Control-word handshake bundle between the microprogram sequencer (master)
//  and param_datapath (slave).
//  Signals:
//   cw_valid   master -> slave   control word valid
//   cw_ready   slave  -> master  datapath accepts the word this cycle
//   ctrl_word  master -> slave   {d_addr,a_addr,b_addr,mb,fsel[3:0],md,we}
//   const_in   master -> slave   constant operand (mb=1 selects it for B)
//   data_in    master -> slave   external load data (md=1 writes it)
// ---------------------------------------------------------------------------
interface param_datapath_if #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int CW_W   = 3 * ADDR_W + 7;

  logic              cw_valid;
  logic              cw_ready;
  logic [CW_W-1:0]   ctrl_word;
  logic [DATA_W-1:0] const_in;
  logic [DATA_W-1:0] data_in;

  modport master (
    output cw_valid, ctrl_word, const_in, data_in,
    input  cw_ready
  );

  modport slave (
    input  cw_valid, ctrl_word, const_in, data_in,
    output cw_ready
  );
endinterface

// File: rtl/param_datapath.sv
// ---------------------------------------------------------------------------
// param_datapath
//  Two-stage (EX -> WB) datapath: NUM_REGS x DATA_W register file, operand
//  muxes, 16-op function unit, registered Z/N/C/V flags and a shift-add
//  multiplier that takes DATA_W cycles.
//  Build option: define DP_FORWARD_EN to bypass WB data into EX on a
//  read-after-write hazard; without it the word is held off (cw_ready=0) for
//  one cycle while the WB write lands.
//  Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   bus            param_datapath_if.slave (cw_valid/cw_ready/ctrl_word/
//                  const_in/data_in)
//   flag_z/n/c/v   registered zero/negative/carry/overflow
//   busy           multiply in progress
//   reg_flat       R[i] at [i*DATA_W +: DATA_W]
// ---------------------------------------------------------------------------
module param_datapath #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  param_datapath_if.slave            bus,
  output logic                       flag_z,
  output logic                       flag_n,
  output logic                       flag_c,
  output logic                       flag_v,
  output logic                       busy,
  output logic [NUM_REGS*DATA_W-1:0] reg_flat
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int MSB    = DATA_W - 1;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t              state;
  logic [DATA_W-1:0]   rf [NUM_REGS];

  // WB stage
  logic                wb_valid;
  logic                wb_we;
  logic [ADDR_W-1:0]   wb_addr;
  logic [DATA_W-1:0]   wb_data;

  // Multiplier state
  logic [2*DATA_W-1:0] mul_mcand;
  logic [DATA_W-1:0]   mul_mplier;
  logic [2*DATA_W-1:0] mul_prod;
  logic [2*DATA_W-1:0] prod_next;
  logic [CNT_W-1:0]    mul_cnt;
  logic [ADDR_W-1:0]   mul_addr;
  logic                mul_we;

  // Control word fields
  logic                we;
  logic                md;
  logic [3:0]          fsel;
  logic                mb;
  logic [ADDR_W-1:0]   b_addr;
  logic [ADDR_W-1:0]   a_addr;
  logic [ADDR_W-1:0]   d_addr;

  logic                a_hit;
  logic                b_hit;
  logic                stall;
  logic                ready;
  logic                accept;
  logic                is_mul;
  logic [DATA_W-1:0]   a_op;
  logic [DATA_W-1:0]   b_op;
  logic [DATA_W-1:0]   y;
  logic                cin;
  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   res;
  logic                c_out;
  logic                v_out;
  logic [DATA_W-1:0]   d_val;

  assign we     = bus.ctrl_word[0];
  assign md     = bus.ctrl_word[1];
  assign fsel   = bus.ctrl_word[5:2];
  assign mb     = bus.ctrl_word[6];
  assign b_addr = bus.ctrl_word[7 +: ADDR_W];
  assign a_addr = bus.ctrl_word[7 + ADDR_W +: ADDR_W];
  assign d_addr = bus.ctrl_word[7 + 2*ADDR_W +: ADDR_W];

  // Operand fetch; a pending WB write to a read address is either bypassed or interlocked.
  always_comb begin
    a_hit = wb_valid & wb_we & (wb_addr == a_addr);
    b_hit = wb_valid & wb_we & ~mb & (wb_addr == b_addr);
`ifdef DP_FORWARD_EN
    stall = 1'b0;
    a_op  = a_hit ? wb_data : rf[a_addr];
    if (mb) begin
      b_op = bus.const_in;
    end else if (b_hit) begin
      b_op = wb_data;
    end else begin
      b_op = rf[b_addr];
    end
`else
    stall = bus.cw_valid & (a_hit | b_hit);
    a_op  = rf[a_addr];
    b_op  = mb ? bus.const_in : rf[b_addr];
`endif
  end

  assign ready        = ~rst & (state == S_IDLE) & ~stall;
  assign bus.cw_ready = ready;
  assign accept       = bus.cw_valid & ready;
  assign is_mul       = (fsel == 4'hF) & ~md;

  // Function unit: all add/sub forms share one DATA_W+1 adder as A + y + cin.
  always_comb begin
    y     = '0;
    cin   = 1'b0;
    res   = '0;
    c_out = 1'b0;
    v_out = 1'b0;
    case (fsel)
      4'h1:    begin y = '0;    cin = 1'b1; end
      4'h2:    begin y = b_op;  cin = 1'b0; end
      4'h3:    begin y = b_op;  cin = 1'b1; end
      4'h4:    begin y = ~b_op; cin = 1'b0; end
      4'h5:    begin y = ~b_op; cin = 1'b1; end
      4'h6:    begin y = '1;    cin = 1'b0; end
      default: begin y = '0;    cin = 1'b0; end
    endcase
    sum = {1'b0, a_op} + {1'b0, y} + {{DATA_W{1'b0}}, cin};
    case (fsel)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
        res   = sum[MSB:0];
        c_out = sum[DATA_W];
        // Signed overflow: operands agree in sign but the result does not.
        v_out = (a_op[MSB] == y[MSB]) & (sum[MSB] != a_op[MSB]);
      end
      4'h0, 4'h7: res = a_op;
      4'h8:       res = a_op & b_op;
      4'h9:       res = a_op | b_op;
      4'hA:       res = a_op ^ b_op;
      4'hB:       res = ~a_op;
      4'hC:       res = b_op;
      4'hD: begin
        res   = {1'b0, b_op[MSB:1]};
        c_out = b_op[0];
      end
      4'hE: begin
        res   = {b_op[MSB-1:0], 1'b0};
        c_out = b_op[MSB];
      end
      default:    res = '0;  // multiply result comes from the FSM
    endcase
  end

  assign d_val     = md ? bus.data_in : res;
  assign prod_next = mul_prod + (mul_mplier[0] ? mul_mcand : {(2*DATA_W){1'b0}});

  // Control FSM, WB stage latch, flag register and shift-add multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      flag_z     <= 1'b0;
      flag_n     <= 1'b0;
      flag_c     <= 1'b0;
      flag_v     <= 1'b0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_prod   <= '0;
      mul_cnt    <= '0;
      mul_addr   <= '0;
      mul_we     <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              // Operands are frozen here; the RF may change underneath.
              state      <= S_MUL;
              busy       <= 1'b1;
              mul_mcand  <= {{DATA_W{1'b0}}, a_op};
              mul_mplier <= b_op;
              mul_prod   <= '0;
              mul_cnt    <= '0;
              mul_addr   <= d_addr;
              mul_we     <= we;
            end else begin
              wb_valid <= 1'b1;
              wb_we    <= we;
              wb_addr  <= d_addr;
              wb_data  <= d_val;
              if (!md) begin
                flag_z <= (res == '0);
                flag_n <= res[MSB];
                flag_c <= c_out;
                flag_v <= v_out;
              end
            end
          end
        end
        S_MUL: begin
          mul_prod   <= prod_next;
          mul_mcand  <= {mul_mcand[2*DATA_W-2:0], 1'b0};
          mul_mplier <= {1'b0, mul_mplier[MSB:1]};
          mul_cnt    <= mul_cnt + CNT_W'(1);
          if (mul_cnt == CNT_W'(DATA_W - 1)) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            wb_valid <= 1'b1;
            wb_we    <= mul_we;
            wb_addr  <= mul_addr;
            wb_data  <= prod_next[MSB:0];
            flag_z   <= (prod_next[MSB:0] == '0);
            flag_n   <= prod_next[MSB];
            flag_c   <= |prod_next[2*DATA_W-1:DATA_W];
            flag_v   <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Register file write port, fed only by the WB stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf[i] <= '0;
      end
    end else if (wb_valid && wb_we) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // Flatten the register file for display/debug.
  always_comb begin
    reg_flat = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_flat[i*DATA_W +: DATA_W] = rf[i];
    end
  end
endmodule

// File: tb/tb_param_datapath.sv
// ---------------------------------------------------------------------------
// tb_param_datapath
//  Directed + random stimulus for param_datapath (DATA_W=8, NUM_REGS=8).
//  The driver runs an architectural model on every accepted word and queues
//  the expected flags and register file with the cycle they become visible;
//  a monitor process pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_param_datapath;
  localparam int DW   = 8;
  localparam int NR   = 8;
  localparam int CW_W = 16;

  typedef struct {
    int               due;
    logic [NR*DW-1:0] regs;
    logic [3:0]       flags;   // {z,n,c,v}
  } exp_t;

  logic clk;
  logic rst;
  logic flag_z, flag_n, flag_c, flag_v, busy;
  logic [NR*DW-1:0] reg_flat;

  param_datapath_if #(.DATA_W(DW), .NUM_REGS(NR)) bus ();

  param_datapath #(.DATA_W(DW), .NUM_REGS(NR)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .flag_z   (flag_z),
    .flag_n   (flag_n),
    .flag_c   (flag_c),
    .flag_v   (flag_v),
    .busy     (busy),
    .reg_flat (reg_flat)
  );

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t flag_q[$];
  exp_t reg_q[$];

  int   m_rf [NR];
  logic m_z, m_n, m_c, m_v;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=timeout required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h required=%h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] f;
    f = '0;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = m_rf[i][DW-1:0];
    return f;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) m_rf[i] = 0;
    {m_z, m_n, m_c, m_v} = 4'b0000;
  endfunction

  // Architectural effect of one accepted word, plus queueing of expectations.
  function automatic void model_accept(input logic [CW_W-1:0] w, input logic [DW-1:0] k,
                                       input logic [DW-1:0] d, input int e);
    int   aa, ba, da, f, a, b, sa, sb, r, sv, res;
    bit   we, md, mb, c, arith, is_mul;
    exp_t fe, re;
    we = w[0]; md = w[1]; f = int'(w[5:2]); mb = w[6];
    ba = int'(w[9:7]); aa = int'(w[12:10]); da = int'(w[15:13]);
    a  = m_rf[aa];
    b  = mb ? int'(k) : m_rf[ba];
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    c = 1'b0; arith = 1'b0; sv = 0; r = 0;
    case (f)
      1:  begin r = a + 1;         c = (r > 255); sv = sa + 1;      arith = 1'b1; end
      2:  begin r = a + b;         c = (r > 255); sv = sa + sb;     arith = 1'b1; end
      3:  begin r = a + b + 1;     c = (r > 255); sv = sa + sb + 1; arith = 1'b1; end
      4:  begin r = a + 255 - b;   c = (a > b);   sv = sa - sb - 1; arith = 1'b1; end
      5:  begin r = a - b;         c = (a >= b);  sv = sa - sb;     arith = 1'b1; end
      6:  begin r = a - 1;         c = (a >= 1);  sv = sa - 1;      arith = 1'b1; end
      8:  r = a & b;
      9:  r = a | b;
      10: r = a ^ b;
      11: r = 255 - a;
      12: r = b;
      13: begin r = b / 2;         c = b[0]; end
      14: begin r = (b * 2) % 256; c = (b > 127); end
      15: begin r = a * b;         c = (r > 255); end
      default: r = a;
    endcase
    res    = r & 255;
    is_mul = (f == 15) && !md;
    if (md) begin
      res = int'(d);
    end else begin
      m_z = (res == 0);
      m_n = (res > 127);
      m_c = c;
      m_v = arith && (sv < -128 || sv > 127);
    end
    if (we) m_rf[da] = res;
    fe.due   = is_mul ? e + DW : e;
    fe.regs  = '0;
    fe.flags = {m_z, m_n, m_c, m_v};
    re.due   = is_mul ? e + DW + 1 : e + 1;
    re.regs  = model_flat();
    re.flags = 4'b0000;
    flag_q.push_back(fe);
    reg_q.push_back(re);
  endfunction

  // Monitor: pop expectations as they become due and compare.
  initial forever begin
    @(negedge clk);
    while (flag_q.size() > 0 && flag_q[0].due <= cyc) begin
      exp_t x;
      x = flag_q.pop_front();
      chk("flags_zncv", {60'd0, flag_z, flag_n, flag_c, flag_v}, {60'd0, x.flags});
    end
    while (reg_q.size() > 0 && reg_q[0].due <= cyc) begin
      exp_t x;
      x = reg_q.pop_front();
      chk("reg_flat", reg_flat, x.regs);
    end
  end

  function automatic logic [CW_W-1:0] mkcw(input int d, input int a, input int b, input bit mb,
                                           input int f, input bit md, input bit we);
    logic [CW_W-1:0] w;
    w = {3'(d), 3'(a), 3'(b), mb, 4'(f), md, we};
    return w;
  endfunction

  // Present one word (from posedge+1) until accepted; reports cycles spent waiting.
  task automatic issue(input logic [CW_W-1:0] w, input logic [DW-1:0] k,
                       input logic [DW-1:0] d, output int stalls);
    bit done;
    done   = 1'b0;
    stalls = 0;
    bus.cw_valid  = 1'b1;
    bus.ctrl_word = w;
    bus.const_in  = k;
    bus.data_in   = d;
    for (int t = 0; t < 40 && !done; t++) begin
      #8;
      if (bus.cw_ready) begin
        model_accept(w, k, d, cyc + 1);
        done = 1'b1;
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
    end
    bus.cw_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout cyc=%0d got=no_accept required=accept", cyc);
    end
  endtask

  task automatic idle(input int n);
    bus.cw_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int st, low, bz;
    bit seen;
    logic [DW-1:0] tmp;
    rst = 1'b1;
    bus.cw_valid  = 1'b0;
    bus.ctrl_word = '0;
    bus.const_in  = '0;
    bus.data_in   = '0;
    model_reset();

    // Reset: two cycles
    @(posedge clk); #1;
    #8 chk("ready_in_rst", {63'd0, bus.cw_ready}, 64'd0);
    @(posedge clk); #1;
    chk("rst_reg_flat", reg_flat, 64'd0);
    chk("rst_flags", {60'd0, flag_z, flag_n, flag_c, flag_v}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    #8 chk("ready_after_rst", {63'd0, bus.cw_ready}, 64'd1);
    @(posedge clk); #1;

    // R1=5, then R2=R1+R1 back to back
    issue(mkcw(1, 0, 0, 1'b0, 0, 1'b1, 1'b1), 8'h00, 8'h05, st);
    issue(mkcw(2, 1, 1, 1'b0, 2, 1'b0, 1'b1), 8'h00, 8'h00, st);
`ifdef DP_FORWARD_EN
    chk("raw_stall_cycles", 64'(st), 64'd0);
`else
    chk("raw_stall_cycles", 64'(st), 64'd1);
`endif
    idle(2);
    chk("r2_add", {56'd0, reg_flat[2*DW +: DW]}, 64'h0A);

    // R3 = R2 - 0x0B
    issue(mkcw(3, 2, 0, 1'b1, 5, 1'b0, 1'b1), 8'h0B, 8'h00, st);
    idle(2);
    chk("r3_sub", {56'd0, reg_flat[3*DW +: DW]}, 64'hFF);
    chk("sub_flags", {60'd0, flag_z, flag_n, flag_c, flag_v}, 64'b0100);

    // R4=0x7F, R5=0x01, R6=R4+R5 overflows
    issue(mkcw(4, 0, 0, 1'b0, 0, 1'b1, 1'b1), 8'h00, 8'h7F, st);
    issue(mkcw(5, 0, 0, 1'b0, 0, 1'b1, 1'b1), 8'h00, 8'h01, st);
    issue(mkcw(6, 4, 5, 1'b0, 2, 1'b0, 1'b1), 8'h00, 8'h00, st);
    idle(2);
    chk("r6_add_ovf", {56'd0, reg_flat[6*DW +: DW]}, 64'h80);
    chk("ovf_flags", {60'd0, flag_z, flag_n, flag_c, flag_v}, 64'b0101);

    // R7 = R4 ^ R4 with we=0: flags only
    issue(mkcw(7, 4, 4, 1'b0, 10, 1'b0, 1'b0), 8'h00, 8'h00, st);
    idle(2);
    chk("r7_unwritten", {56'd0, reg_flat[7*DW +: DW]}, 64'h00);
    chk("xor_flags", {60'd0, flag_z, flag_n, flag_c, flag_v}, 64'b1000);

    // Multiply R3 = R1 * R2 = 0x12 * 0x10
    issue(mkcw(1, 0, 0, 1'b0, 0, 1'b1, 1'b1), 8'h00, 8'h12, st);
    issue(mkcw(2, 0, 0, 1'b0, 0, 1'b1, 1'b1), 8'h00, 8'h10, st);
    issue(mkcw(3, 1, 2, 1'b0, 15, 1'b0, 1'b1), 8'h00, 8'h00, st);
    low = 0; bz = 0; seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      #8;
      if (bus.cw_ready) seen = 1'b1;
      else low++;
      if (busy) bz++;
      @(posedge clk); #1;
    end
    chk("mul_ready_low_cycles", 64'(low), 64'd8);
    chk("mul_busy_cycles", 64'(bz), 64'd8);
    idle(2);
    chk("r3_mul", {56'd0, reg_flat[3*DW +: DW]}, 64'h20);
    chk("mul_flags", {60'd0, flag_z, flag_n, flag_c, flag_v}, 64'b0010);

    // Reset three cycles into a multiply
    issue(mkcw(1, 0, 0, 1'b0, 0, 1'b1, 1'b1), 8'h00, 8'h03, st);
    issue(mkcw(2, 0, 0, 1'b0, 0, 1'b1, 1'b1), 8'h00, 8'h04, st);
    issue(mkcw(4, 1, 2, 1'b0, 15, 1'b0, 1'b1), 8'h00, 8'h00, st);
    idle(3);
    rst = 1'b1;
    flag_q.delete();
    reg_q.delete();
    model_reset();
    #8 chk("ready_in_mul_rst", {63'd0, bus.cw_ready}, 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #8;
    chk("abort_ready", {63'd0, bus.cw_ready}, 64'd1);
    chk("abort_regs", reg_flat, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_flags", {60'd0, flag_z, flag_n, flag_c, flag_v}, 64'd0);
    @(posedge clk); #1;

    // Random words against the model
    for (int i = 0; i < 250; i++) begin
      tmp = 8'($urandom);
      issue(16'($urandom), 8'($urandom), tmp, st);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(DW + 4);
    chk("queues_drained", 64'(flag_q.size() + reg_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
